// File: rtl/c3aibadapt_sr_serializer.sv
// Transmit side of the adapter shift-register link: snapshot {fsr, ssr}, shift it out MSB first,
// then strobe sr_load_out so the far end latches the words. Also reports the parity of each frame.
module c3aibadapt_sr_serializer #(
  parameter int FSR_WIDTH  = 1,
  parameter int SSR_WIDTH  = 36,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 sr_clock_tx_osc_clk,
  input  logic                 sr_reset_tx_osc_clk_rst,
  input  logic                 sr_enable,
  input  logic [FSR_WIDTH-1:0] fsr_data_in,
  input  logic [SSR_WIDTH-1:0] ssr_data_in,
  output logic                 sr_data_out,
  output logic                 sr_load_out,
  output logic                 fsr_parity_out,
  output logic                 ssr_parity_out,
  output logic                 sr_frame_done,
  output logic [7:0]           sr_frame_cnt
);

  localparam int N  = FSR_WIDTH + SSR_WIDTH;
  localparam int CW = $clog2(N);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, LOAD} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    shadow, shadow_nxt;
  logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic            fsr_par_q, ssr_par_q;
  logic            data_nxt, load_nxt, done_nxt;
  logic            cap_par, show_par;

  // Outputs are registered, so the comb block computes what they must show next cycle.
  always_comb begin
    state_nxt   = state;
    shadow_nxt  = shadow;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    data_nxt    = 1'b0;
    load_nxt    = 1'b0;
    done_nxt    = 1'b0;
    cap_par     = 1'b0;
    show_par    = 1'b0;
    case (state)
      IDLE: begin
        if (sr_enable) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        shadow_nxt  = {fsr_data_in, ssr_data_in};
        data_nxt    = fsr_data_in[FSR_WIDTH-1];
        bit_cnt_nxt = BIT_LAST;
        cap_par     = 1'b1;
        state_nxt   = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          state_nxt   = LOAD;
          load_nxt    = 1'b1;
          show_par    = 1'b1;
          gap_cnt_nxt = GAP_LAST;
          done_nxt    = (GAP_CYCLES == 1);
        end else begin
          // shadow[N-1] always mirrors the bit currently on the line
          shadow_nxt  = {shadow[N-2:0], 1'b0};
          data_nxt    = shadow[N-2];
          bit_cnt_nxt = bit_cnt - 1'b1;
        end
      end
      LOAD: begin
        if (gap_cnt == '0) begin
          state_nxt = sr_enable ? CAPTURE : IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 1'b1;
          load_nxt    = 1'b1;
          done_nxt    = (gap_cnt == GAP_ONE);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sr_clock_tx_osc_clk) begin
    if (sr_reset_tx_osc_clk_rst) begin
      state          <= IDLE;
      shadow         <= '0;
      bit_cnt        <= '0;
      gap_cnt        <= '0;
      fsr_par_q      <= 1'b0;
      ssr_par_q      <= 1'b0;
      sr_data_out    <= 1'b0;
      sr_load_out    <= 1'b0;
      fsr_parity_out <= 1'b0;
      ssr_parity_out <= 1'b0;
      sr_frame_done  <= 1'b0;
      sr_frame_cnt   <= '0;
    end else begin
      state         <= state_nxt;
      shadow        <= shadow_nxt;
      bit_cnt       <= bit_cnt_nxt;
      gap_cnt       <= gap_cnt_nxt;
      sr_data_out   <= data_nxt;
      sr_load_out   <= load_nxt;
      sr_frame_done <= done_nxt;
      if (cap_par) begin
        fsr_par_q <= ^fsr_data_in;
        ssr_par_q <= ^ssr_data_in;
      end
      if (show_par) begin
        fsr_parity_out <= fsr_par_q;
        ssr_parity_out <= ssr_par_q;
      end
      if (done_nxt) sr_frame_cnt <= sr_frame_cnt + 8'd1;
    end
  end

endmodule
